// File: rtl/axil_axis_loopback_target_if.sv
// Bus bundle for the loopback target: AXI-Lite register port plus the ss (in) and sm (out) streams.
// "slave" is the target's view; "master" is the bridge or testbench side.
interface axil_axis_loopback_target_if #(
    parameter int pADDR_WIDTH = 12,
    parameter int pDATA_WIDTH = 32
);
    logic                   awvalid;
    logic                   awready;
    logic [pADDR_WIDTH-1:0] awaddr;
    logic                   wvalid;
    logic                   wready;
    logic [pDATA_WIDTH-1:0] wdata;
    logic                   arvalid;
    logic                   arready;
    logic [pADDR_WIDTH-1:0] araddr;
    logic                   rvalid;
    logic                   rready;
    logic [pDATA_WIDTH-1:0] rdata;
    logic                   ss_tvalid;
    logic                   ss_tready;
    logic [pDATA_WIDTH-1:0] ss_tdata;
    logic                   ss_tlast;
    logic                   sm_tvalid;
    logic                   sm_tready;
    logic [pDATA_WIDTH-1:0] sm_tdata;
    logic                   sm_tlast;

    modport slave (
        input  awvalid, awaddr, wvalid, wdata, arvalid, araddr, rready,
               ss_tvalid, ss_tdata, ss_tlast, sm_tready,
        output awready, wready, arready, rvalid, rdata,
               ss_tready, sm_tvalid, sm_tdata, sm_tlast
    );

    modport master (
        output awvalid, awaddr, wvalid, wdata, arvalid, araddr, rready,
               ss_tvalid, ss_tdata, ss_tlast, sm_tready,
        input  awready, wready, arready, rvalid, rdata,
               ss_tready, sm_tvalid, sm_tdata, sm_tlast
    );
endinterface

// File: rtl/axil_axis_loopback_target.sv
// AXI-Lite controlled loopback kernel: buffers data_length words from ss and replays them
// on sm in reverse order, reporting completion through ap_ctrl.
module axil_axis_loopback_target #(
    parameter int pADDR_WIDTH = 12,
    parameter int pDATA_WIDTH = 32,
    parameter int pDEPTH      = 64
) (
    input  logic wb_clk_i,
    input  logic wb_rst_i,
    axil_axis_loopback_target_if.slave bus
);
    localparam int AW = $clog2(pDEPTH);
    localparam int LW = AW + 1;

    typedef enum logic {W_ADDR, W_DATA} w_state_t;
    typedef enum logic {R_ADDR, R_DATA} r_state_t;
    typedef enum logic [1:0] {C_IDLE, C_RECV, C_SEND} c_state_t;

    w_state_t w_state, w_next;
    r_state_t r_state, r_next;
    c_state_t c_state, c_next;

    logic [7:0]             aw_addr;
    logic [LW-1:0]          data_length;
    logic [LW-1:0]          wr_cnt;
    logic [LW-1:0]          rd_idx;
    logic                   ap_done;
    logic                   ap_idle;
    logic [pDATA_WIDTH-1:0] rdata_q;
    logic [pDATA_WIDTH-1:0] buf_mem [pDEPTH];

    logic w_hs, ar_hs, ss_hs, sm_hs;
    logic wr_ctrl, wr_len, start_ok, last_in, last_out;
    logic unused_bits;

    function automatic logic [pDATA_WIDTH-1:0] reg_read(input logic [7:0] a, input logic done,
                                                         input logic idle, input logic [LW-1:0] len);
        reg_read = '0;
        case (a)
            8'h00:   reg_read[2:0]    = {idle, done, 1'b0};
            8'h10:   reg_read[LW-1:0] = len;
            default: ;
        endcase
    endfunction

    assign unused_bits = ^{bus.awaddr[pADDR_WIDTH-1:8], bus.araddr[pADDR_WIDTH-1:8],
                           bus.wdata[pDATA_WIDTH-1:LW], bus.ss_tlast};

    assign ap_idle  = (c_state == C_IDLE);
    assign w_hs     = (w_state == W_DATA) && bus.wvalid;
    assign ar_hs    = (r_state == R_ADDR) && bus.arvalid;
    assign ss_hs    = (c_state == C_RECV) && bus.ss_tvalid;
    assign sm_hs    = (c_state == C_SEND) && bus.sm_tready;
    assign wr_ctrl  = w_hs && (aw_addr == 8'h00);
    assign wr_len   = w_hs && (aw_addr == 8'h10);
    assign start_ok = wr_ctrl && bus.wdata[0] && ap_idle &&
                      (data_length != '0) && (data_length <= LW'(pDEPTH));
    assign last_in  = ss_hs && (wr_cnt == data_length - LW'(1));
    assign last_out = sm_hs && (rd_idx == '0);
    assign bus.rdata = rdata_q;

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            w_state <= W_ADDR;
            r_state <= R_ADDR;
            c_state <= C_IDLE;
        end else begin
            w_state <= w_next;
            r_state <= r_next;
            c_state <= c_next;
        end
    end

    // wready depends only on state, so a source may derive wvalid from it without a loop.
    always_comb begin
        w_next      = w_state;
        bus.awready = 1'b0;
        bus.wready  = 1'b0;
        case (w_state)
            W_ADDR: begin
                bus.awready = bus.awvalid;
                if (bus.awvalid) w_next = W_DATA;
            end
            W_DATA: begin
                bus.wready = 1'b1;
                if (bus.wvalid) w_next = W_ADDR;
            end
            default: w_next = W_ADDR;
        endcase
    end

    always_comb begin
        r_next      = r_state;
        bus.arready = 1'b0;
        bus.rvalid  = 1'b0;
        case (r_state)
            R_ADDR: begin
                bus.arready = bus.arvalid;
                if (bus.arvalid) r_next = R_DATA;
            end
            R_DATA: begin
                bus.rvalid = 1'b1;
                if (bus.rready) r_next = R_ADDR;
            end
            default: r_next = R_ADDR;
        endcase
    end

    always_comb begin
        c_next        = c_state;
        bus.ss_tready = 1'b0;
        bus.sm_tvalid = 1'b0;
        bus.sm_tdata  = '0;
        bus.sm_tlast  = 1'b0;
        case (c_state)
            C_IDLE: if (start_ok) c_next = C_RECV;
            C_RECV: begin
                bus.ss_tready = 1'b1;
                if (last_in) c_next = C_SEND;
            end
            C_SEND: begin
                bus.sm_tvalid = 1'b1;
                bus.sm_tdata  = buf_mem[rd_idx[AW-1:0]];
                bus.sm_tlast  = (rd_idx == '0);
                if (last_out) c_next = C_IDLE;
            end
            default: c_next = C_IDLE;
        endcase
    end

    // Read data is captured at address acceptance, so a same-cycle register write is not yet visible.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            aw_addr     <= '0;
            rdata_q     <= '0;
            data_length <= '0;
            ap_done     <= 1'b0;
            wr_cnt      <= '0;
            rd_idx      <= '0;
        end else begin
            if (w_state == W_ADDR && bus.awvalid) aw_addr <= bus.awaddr[7:0];
            if (ar_hs) rdata_q <= reg_read(bus.araddr[7:0], ap_done, ap_idle, data_length);
            if (wr_len && ap_idle) data_length <= bus.wdata[LW-1:0];
            if (last_out) ap_done <= 1'b1;
            else if (start_ok || (ar_hs && bus.araddr[7:0] == 8'h00)) ap_done <= 1'b0;
            if (start_ok) wr_cnt <= '0;
            else if (ss_hs) wr_cnt <= wr_cnt + LW'(1);
            if (last_in) rd_idx <= data_length - LW'(1);
            else if (sm_hs && rd_idx != '0) rd_idx <= rd_idx - LW'(1);
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (ss_hs) buf_mem[wr_cnt[AW-1:0]] <= bus.ss_tdata;
    end
endmodule
